// File: rtl/nn_pkg.sv
// Shared neural-network datapath definitions: float32 word type, IEEE-754
// field masks, the ReLU stage state encoding and a small width helper.
package nn_pkg;

  typedef logic [31:0] float32_t;

  localparam float32_t FP32_POS_ZERO = 32'h0000_0000;
  localparam float32_t FP32_EXP_MASK = 32'h7F80_0000;
  localparam float32_t FP32_MAN_MASK = 32'h007F_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } relu_state_e;

  // Bits needed to index n items, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relu_fp32.sv
// Combinational single-element float32 ReLU done on the raw bit pattern.
// Anything with the sign bit set and every NaN collapse to +0.0; +inf and all
// positive values (subnormals included) pass through untouched.
module relu_fp32
  import nn_pkg::*;
(
  input  float32_t x,
  output float32_t y
);

  logic is_nan;

  assign is_nan = ((x & FP32_EXP_MASK) == FP32_EXP_MASK) && ((x & FP32_MAN_MASK) != FP32_POS_ZERO);
  assign y      = (x[31] || is_nan) ? FP32_POS_ZERO : x;

endmodule

// File: rtl/relu_layer.sv
// Element-wise ReLU stage following the linear layer. The operand matrix is
// snapshotted on start and then walked LANES elements per cycle; results
// land in data_out at their flat position (row*SIZE + col, element i in bits
// [i*32 +: 32]). Handshake: enable level starts a run, done holds until
// enable drops.
// Optional build macro RELU_ARGMAX_EN adds argmax_out, the per-row index of
// the largest post-ReLU element (ties resolve to the lowest index).
module relu_layer
  import nn_pkg::*;
#(
  parameter int COUNT = 1,
  parameter int SIZE  = 2,
  parameter int LANES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  output logic                        done,
  input  logic [COUNT*SIZE*32-1:0]    data_in,
  output logic [COUNT*SIZE*32-1:0]    data_out
`ifdef RELU_ARGMAX_EN
  ,
  output logic [COUNT*idx_width(SIZE)-1:0] argmax_out
`endif
);

  localparam int N     = COUNT * SIZE;
  localparam int DW    = N * 32;
  localparam int IDX_W = $clog2(N + 1);

  // A lane group must never straddle a row boundary.
  if (LANES < 1 || (SIZE % LANES) != 0) begin : g_bad_lanes
    $error("relu_layer: LANES must divide SIZE");
  end

  relu_state_e         state_reg, state_next;
  logic [DW-1:0]       buf_reg;
  logic [DW-1:0]       data_out_reg, data_out_next;
  logic [IDX_W-1:0]    idx_reg;
  logic                start, running, last_step;
  logic [LANES*32-1:0] lane_window;
  float32_t            lane_out [LANES];

  assign last_step = (idx_reg == IDX_W'(N - LANES));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state: enable is only looked at in IDLE and DONE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable)    state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (!enable)   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Control outputs decoded from the current state
  always_comb begin
    start   = 1'b0;
    running = 1'b0;
    done    = 1'b0;
    case (state_reg)
      IDLE:    start   = enable;
      RUN:     running = 1'b1;
      DONE:    done    = 1'b1;
      default: ;
    endcase
  end

  // Operand snapshot and element index
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_reg <= '0;
      idx_reg <= '0;
    end else if (start) begin
      buf_reg <= data_in;
      idx_reg <= '0;
    end else if (running) begin
      idx_reg <= idx_reg + IDX_W'(LANES);
    end
  end

  // The current lane group, shifted down to the bottom of the buffer
  assign lane_window = (LANES*32)'(buf_reg >> {idx_reg, 5'b0});

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    relu_fp32 u_relu (
      .x(lane_window[gi*32 +: 32]),
      .y(lane_out[gi])
    );
  end

  // Groups are LANES-aligned, so element gi is always served by lane gi % LANES
  for (genvar gi = 0; gi < N; gi++) begin : g_elem
    assign data_out_next[gi*32 +: 32] =
      (running && idx_reg == IDX_W'((gi / LANES) * LANES)) ? lane_out[gi % LANES]
                                                            : data_out_reg[gi*32 +: 32];
  end

  // Result register: cleared on start, filled group by group, held afterwards
  always_ff @(posedge clk) begin
    if (rst || start) data_out_reg <= '0;
    else              data_out_reg <= data_out_next;
  end

  assign data_out = data_out_reg;

`ifdef RELU_ARGMAX_EN
  localparam int AW = idx_width(SIZE);

  logic [IDX_W-1:0] cur_row;
  logic [AW-1:0]    col_base;

  assign cur_row  = idx_reg / IDX_W'(SIZE);
  assign col_base = AW'(idx_reg % IDX_W'(SIZE));

  for (genvar gi = 0; gi < COUNT; gi++) begin : g_row
    float32_t      best_reg, cand_val;
    logic [AW-1:0] arg_reg, cand_arg;

    // Post-ReLU words are non-negative, so an unsigned compare orders them;
    // strict > in ascending lane order keeps the lowest index on ties
    always_comb begin
      cand_val = best_reg;
      cand_arg = arg_reg;
      for (int l = 0; l < LANES; l++) begin
        if (lane_out[l] > cand_val) begin
          cand_val = lane_out[l];
          cand_arg = col_base + AW'(l);
        end
      end
    end

    // Running maximum for this row, updated only while its elements stream by
    always_ff @(posedge clk) begin
      if (rst || start) begin
        best_reg <= FP32_POS_ZERO;
        arg_reg  <= '0;
      end else if (running && cur_row == IDX_W'(gi)) begin
        best_reg <= cand_val;
        arg_reg  <= cand_arg;
      end
    end

    assign argmax_out[gi*AW +: AW] = arg_reg;
  end
`endif

endmodule

// File: tb/tb_relu_layer.sv
// Self-checking bench for relu_layer: a 2x4 two-lane instance carries most
// of the work, a default 1x2 single-lane instance covers the basic case.
// Expected values come from a float32 ReLU model written from the rules.
module tb_relu_layer;

  localparam int CA = 2, SA = 4, LA = 2, KA = CA*SA/LA;
  localparam int CB = 1, SB = 2, LB = 1, KB = CB*SB/LB;
  localparam int DWA = CA*SA*32, DWB = CB*SB*32;
  localparam int AWA = 2, AWB = 1;

  logic clk = 1'b0;
  logic rst;
  logic en_a, en_b, done_a, done_b;
  logic [DWA-1:0] din_a, dout_a;
  logic [DWB-1:0] din_b, dout_b;
`ifdef RELU_ARGMAX_EN
  logic [CA*AWA-1:0] amax_a;
  logic [CB*AWB-1:0] amax_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  relu_layer #(.COUNT(CA), .SIZE(SA), .LANES(LA)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .done(done_a),
    .data_in(din_a), .data_out(dout_a)
`ifdef RELU_ARGMAX_EN
    , .argmax_out(amax_a)
`endif
  );

  relu_layer dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .done(done_b),
    .data_in(din_b), .data_out(dout_b)
`ifdef RELU_ARGMAX_EN
    , .argmax_out(amax_b)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] relu_ref(input logic [31:0] x);
    if (x[31]) return 32'h0;
    if (x[30:23] == 8'hFF && x[22:0] != 23'h0) return 32'h0;
    return x;
  endfunction

  function automatic logic [DWA-1:0] model_a(input logic [DWA-1:0] d);
    logic [DWA-1:0] r;
    for (int i = 0; i < CA*SA; i++) r[i*32 +: 32] = relu_ref(d[i*32 +: 32]);
    return r;
  endfunction

  function automatic logic [CA*AWA-1:0] argmax_model_a(input logic [DWA-1:0] d);
    logic [CA*AWA-1:0] r;
    logic [31:0] best, v;
    int bi;
    r = '0;
    for (int row = 0; row < CA; row++) begin
      best = 32'h0;
      bi = 0;
      for (int c = 0; c < SA; c++) begin
        v = relu_ref(d[(row*SA + c)*32 +: 32]);
        if (v > best) begin
          best = v;
          bi = c;
        end
      end
      r[row*AWA +: AWA] = AWA'(bi);
    end
    return r;
  endfunction

  // Random word biased towards the interesting encodings, sometimes repeating prev
  function automatic logic [31:0] gen_word(input logic [31:0] prev);
    case ($urandom_range(0, 8))
      0: return 32'h8000_0000;
      1: return {1'b0, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      2: return {1'b1, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      3: return 32'h7F80_0000;
      4: return 32'hFF80_0000;
      5: return {9'h0, 23'($urandom_range(1, 32'h7F_FFFF))};
      6: return prev;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [DWA-1:0] gen_matrix();
    logic [DWA-1:0] d;
    logic [31:0] prev;
    prev = 32'h3F80_0000;
    for (int i = 0; i < CA*SA; i++) begin
      d[i*32 +: 32] = gen_word(prev);
      prev = d[i*32 +: 32];
    end
    return d;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [DWA-1:0] got, input logic [DWA-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run on instance A; hold=1 keeps enable high into DONE
  task automatic run_a(input logic [DWA-1:0] d, input bit hold, input string tag);
    logic [DWA-1:0] exp;
    int n;
    exp = model_a(d);
    din_a = d;
    en_a = 1'b1;
    tick();
    check({tag, "_clear"}, dout_a, '0);
    check({tag, "_busy"}, DWA'(done_a), '0);
    din_a = ~d ^ DWA'($urandom);
    if (!hold) en_a = 1'b0;
    n = 0;
    while (!done_a && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, DWA'(n), DWA'(KA));
    check({tag, "_data"}, dout_a, exp);
`ifdef RELU_ARGMAX_EN
    check({tag, "_argmax"}, DWA'(amax_a), DWA'(argmax_model_a(d)));
`endif
    if (!hold) begin
      tick();
      check({tag, "_done_pulse"}, DWA'(done_a), '0);
      tick();
      check({tag, "_no_restart"}, DWA'(done_a), '0);
    end else begin
      repeat (3) tick();
      check({tag, "_done_held"}, DWA'(done_a), DWA'(1));
      check({tag, "_data_held"}, dout_a, exp);
      en_a = 1'b0;
      tick();
      check({tag, "_done_drop"}, DWA'(done_a), '0);
      check({tag, "_data_kept"}, dout_a, exp);
    end
    $display("run %s: data=%h result=%h cycles=%0d", tag, d, dout_a, n);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DWA-1:0] d;
    int n;

    rst = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    din_a = '0;
    din_b = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_done_a", DWA'(done_a), '0);
    check("reset_data_a", dout_a, '0);
    check("reset_done_b", DWA'(done_b), '0);
    check("reset_data_b", DWA'(dout_b), '0);
`ifdef RELU_ARGMAX_EN
    check("reset_argmax_a", DWA'(amax_a), '0);
`endif

    // 1x2 single lane: {5.0, -3.0}, enable held
    din_b = {32'hC040_0000, 32'h40A0_0000};
    en_b = 1'b1;
    tick();
    n = 0;
    while (!done_b && n < 50) begin
      tick();
      n++;
    end
    check("basic_latency", DWA'(n), DWA'(KB));
    check("basic_data", DWA'(dout_b), DWA'({32'h0, 32'h40A0_0000}));
`ifdef RELU_ARGMAX_EN
    check("basic_argmax", DWA'(amax_b), '0);
`endif
    en_b = 1'b0;
    tick();
    check("basic_done_drop", DWA'(done_b), '0);
    $display("run basic: result=%h cycles=%0d", dout_b, n);

    // Special encodings in row 0, random row 1; enable dropped during RUN
    d = gen_matrix();
    d[127:0] = {32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000};
    run_a(d, 1'b0, "special");

    // Argmax pattern rows {1,3,3,-7} and {-1,-2,-0,-5}
    d = {32'hC0A0_0000, 32'h8000_0000, 32'hC000_0000, 32'hBF80_0000,
         32'hC0E0_0000, 32'h4040_0000, 32'h4040_0000, 32'h3F80_0000};
    run_a(d, 1'b0, "argmax");

    // Randomised runs
    for (int r = 0; r < 6; r++) run_a(gen_matrix(), 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));

    // Reset during the second RUN cycle aborts the run
    din_a = gen_matrix();
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_done", DWA'(done_a), '0);
    check("abort_data", dout_a, '0);
    repeat (KA + 1) tick();
    check("abort_idle", DWA'(done_a), '0);
    $display("run abort: result=%h", dout_a);
    run_a(gen_matrix(), 1'b0, "after_abort");

    // Back-to-back: hold through DONE, one low cycle, then new data
    run_a(gen_matrix(), 1'b1, "b2b_first");
    run_a(gen_matrix(), 1'b0, "b2b_second");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
